proximity_sensor_encoder: RTL and testbench

//  Ultrasonic ranging front end that drives the body controller's distance-detection FSM.

---
 rtl/proximity_sensor_encoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_proximity_sensor_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proximity_sensor_encoder.sv
// Alternating front/rear ultrasonic ranging: trigger, time the echo, quantise to 5-bit distance codes.
// Optional DIST_FILTER_EN: publish a measurement only when it repeats the previous code for that side.
module proximity_sensor_encoder #(
    parameter int TRIG_CYCLES    = 10,
    parameter int TICKS_PER_FOOT = 16,
    parameter int ECHO_TIMEOUT   = 512,
    parameter int PING_GAP       = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic       echo_front,
    input  logic       echo_rear,
    output logic       trig_front,
    output logic       trig_rear,
    output logic       front,
    output logic       rear,
    output logic [4:0] distance,
    output logic       distance_valid,
    output logic       meas_side,
    output logic       timeout_err
);
    localparam int CW = 16;
    localparam int TW = $clog2(TICKS_PER_FOOT);
    localparam logic [CW-1:0] GAP_LAST     = CW'(PING_GAP - 1);
    localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ECHO_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [TW-1:0] TICK_LAST    = TW'(TICKS_PER_FOOT - 1);
    localparam logic [TW-1:0] TICK_ONE     = TW'(1);
    localparam logic [4:0]    FEET_MAX     = 5'd21;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_REPORT
    } state_t;

    state_t        state_reg, state_next;
    logic          side_reg, side_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic [4:0]    feet_reg, feet_next;
    logic          echo_prev_reg;
    logic          report_go, report_timeout, accept;
    logic [5:0]    result;

    logic       trig_front_reg, trig_rear_reg, front_reg, rear_reg;
    logic [4:0] distance_reg;
    logic       distance_valid_reg, meas_side_reg, timeout_err_reg;

    logic [1:0] echo_raw, echo_sync;
    logic       echo_sel, echo_rise;

    assign echo_raw = {echo_rear, echo_front};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg, sync_reg;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= echo_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign echo_sync[gi] = sync_reg;
        end
    endgenerate

    // Only the side being pinged is listened to; an echo already high on entry never makes a rise
    assign echo_sel  = echo_sync[side_reg];
    assign echo_rise = echo_sel && !echo_prev_reg;

    // Result packing: {object_present, distance_code}
    function automatic logic [5:0] quantise(input logic [4:0] ft);
        logic [5:0] q;
        if (ft == 5'd0)       q = 6'b10_0000;
        else if (ft <= 5'd5)  q = {1'b1, ft};
        else if (ft <= 5'd10) q = {1'b1, 5'd10};
        else if (ft <= 5'd15) q = {1'b1, 5'd15};
        else if (ft <= 5'd20) q = {1'b1, 5'd20};
        else                  q = 6'd0;
        return q;
    endfunction

    assign result = report_timeout ? 6'd0 : quantise(feet_reg);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= S_IDLE;
            side_reg      <= 1'b0;
            cnt_reg       <= '0;
            tick_reg      <= '0;
            feet_reg      <= '0;
            echo_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            side_reg      <= side_next;
            cnt_reg       <= cnt_next;
            tick_reg      <= tick_next;
            feet_reg      <= feet_next;
            echo_prev_reg <= echo_sel;
        end
    end

    always_comb begin
        state_next     = state_reg;
        side_next      = side_reg;
        cnt_next       = cnt_reg;
        tick_next      = tick_reg;
        feet_next      = feet_reg;
        report_go      = 1'b0;
        report_timeout = 1'b0;
        if (!enable && state_reg != S_REPORT) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_next = S_TRIG;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                S_TRIG: begin
                    if (cnt_reg == TRIG_LAST) begin
                        state_next = S_WAIT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    // The rising cycle is itself the first echo-high tick
                    if (echo_rise) begin
                        state_next = S_MEAS;
                        cnt_next   = CNT_ONE;
                        tick_next  = TICK_ONE;
                        feet_next  = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next     = S_REPORT;
                        report_go      = 1'b1;
                        report_timeout = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                S_MEAS: begin
                    if (!echo_sel) begin
                        state_next = S_REPORT;
                        report_go  = 1'b1;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next     = S_REPORT;
                        report_go      = 1'b1;
                        report_timeout = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                        if (tick_reg == TICK_LAST) begin
                            tick_next = '0;
                            if (feet_reg != FEET_MAX) feet_next = feet_reg + 5'd1;
                        end else begin
                            tick_next = tick_reg + TICK_ONE;
                        end
                    end
                end
                S_REPORT: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    side_next  = ~side_reg;
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

`ifdef DIST_FILTER_EN
    logic [1:0] filt_match;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic [5:0] code_reg;
            logic       valid_reg;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    code_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (report_go && side_reg == 1'(gi)) begin
                    code_reg  <= result;
                    valid_reg <= 1'b1;
                end
            end
            assign filt_match[gi] = valid_reg && (code_reg == result);
        end
    endgenerate
    assign accept = filt_match[side_reg];
`else
    assign accept = 1'b1;
`endif

    // Outputs register on the transition into REPORT so the strobe coincides with the REPORT cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            trig_front_reg     <= 1'b0;
            trig_rear_reg      <= 1'b0;
            front_reg          <= 1'b0;
            rear_reg           <= 1'b0;
            distance_reg       <= '0;
            distance_valid_reg <= 1'b0;
            meas_side_reg      <= 1'b0;
            timeout_err_reg    <= 1'b0;
        end else begin
            trig_front_reg     <= (state_next == S_TRIG) && !side_next;
            trig_rear_reg      <= (state_next == S_TRIG) && side_next;
            distance_valid_reg <= report_go && accept;
            timeout_err_reg    <= report_timeout;
            if (report_go && accept) begin
                meas_side_reg <= side_reg;
                distance_reg  <= result[4:0];
                if (side_reg) rear_reg <= result[5];
                else          front_reg <= result[5];
            end
        end
    end

    assign trig_front     = trig_front_reg;
    assign trig_rear      = trig_rear_reg;
    assign front          = front_reg;
    assign rear           = rear_reg;
    assign distance       = distance_reg;
    assign distance_valid = distance_valid_reg;
    assign meas_side      = meas_side_reg;
    assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_proximity_sensor_encoder.sv
// Directed ping sequence for proximity_sensor_encoder; a pulse-width model is compared every cycle.
module tb_proximity_sensor_encoder;
    localparam int TRIG_CYCLES    = 10;
    localparam int TICKS_PER_FOOT = 16;
    localparam int ECHO_TIMEOUT   = 512;
    localparam int PING_GAP       = 64;

    localparam int K_PULSE      = 0;
    localparam int K_NONE       = 1;
    localparam int K_STUCK_WAIT = 2;
    localparam int K_STUCK_MEAS = 3;
    localparam int K_ABORT      = 4;
    localparam int K_RESET      = 5;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       enable = 1'b0;
    logic       echo_front = 1'b0;
    logic       echo_rear = 1'b0;
    logic       trig_front, trig_rear, front, rear;
    logic [4:0] distance;
    logic       distance_valid, meas_side, timeout_err;

    proximity_sensor_encoder #(
        .TRIG_CYCLES   (TRIG_CYCLES),
        .TICKS_PER_FOOT(TICKS_PER_FOOT),
        .ECHO_TIMEOUT  (ECHO_TIMEOUT),
        .PING_GAP      (PING_GAP)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .enable        (enable),
        .echo_front    (echo_front),
        .echo_rear     (echo_rear),
        .trig_front    (trig_front),
        .trig_rear     (trig_rear),
        .front         (front),
        .rear          (rear),
        .distance      (distance),
        .distance_valid(distance_valid),
        .meas_side     (meas_side),
        .timeout_err   (timeout_err)
    );

    initial forever #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Expected DUT outputs
    logic       m_front = 1'b0, m_rear = 1'b0, m_side = 1'b0, m_valid = 1'b0, m_to = 1'b0;
    logic [4:0] m_dist = 5'd0;
    logic [5:0] f_code [2];
    bit         f_v [2];
    bit         gap_known = 1'b0;
    bit         abort_run = 1'b0;

    typedef struct {
        int         kind;
        int         n;
        bit         side;
        logic [4:0] lit_dist;
        bit         lit_flag;
        bit         lit_strobe;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("distance_valid", 32'(distance_valid), 32'(m_valid));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        chk("distance", 32'(distance), 32'(m_dist));
        chk("meas_side", 32'(meas_side), 32'(m_side));
        chk("front", 32'(front), 32'(m_front));
        chk("rear", 32'(rear), 32'(m_rear));
        chk("trig_exclusive", 32'(trig_front & trig_rear), 0);
    end

    // {present, code} from echo-high length in cycles
    function automatic logic [5:0] model_result(input int n);
        int ft;
        ft = n / TICKS_PER_FOOT;
        if (ft >= 21) return 6'd0;
        if (ft == 0)  return 6'b10_0000;
        if (ft <= 5)  return {1'b1, 5'(ft)};
        if (ft <= 10) return {1'b1, 5'd10};
        if (ft <= 15) return {1'b1, 5'd15};
        return {1'b1, 5'd20};
    endfunction

    task automatic model_reset();
        m_front = 1'b0; m_rear = 1'b0; m_side = 1'b0;
        m_valid = 1'b0; m_to = 1'b0; m_dist = 5'd0;
        f_code[0] = 6'd0; f_code[1] = 6'd0;
        f_v[0] = 1'b0; f_v[1] = 1'b0;
    endtask

    task automatic set_echo(input bit side, input logic v);
        if (side) echo_rear = v;
        else      echo_front = v;
    endtask

    // Called #1 after the edge that should raise the strobe
    task automatic model_report(input vec_t v, input bit to);
        logic [5:0] res;
        bit upd;
        res = to ? 6'd0 : model_result(v.n);
`ifdef DIST_FILTER_EN
        upd = f_v[v.side] && (f_code[v.side] == res);
        f_code[v.side] = res;
        f_v[v.side] = 1'b1;
`else
        upd = 1'b1;
`endif
        m_to = to;
        if (upd) begin
            m_valid = 1'b1;
            m_dist  = res[4:0];
            m_side  = v.side;
            if (v.side) m_rear = res[5];
            else        m_front = res[5];
        end
        chk("lit_strobe", 32'(distance_valid), 32'(v.lit_strobe));
        chk("lit_distance", 32'(distance), 32'(v.lit_dist));
        chk("lit_flag", 32'(v.side ? rear : front), 32'(v.lit_flag));
        chk("lit_timeout", 32'(timeout_err), 32'(to));
        @(posedge CLK); #1;
        m_valid = 1'b0;
        m_to = 1'b0;
        gap_known = 1'b1;
    endtask

    task automatic run_ping(input vec_t v);
        int  cnt, w;
        bit  seen;
        seen = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            cnt++;
            if (trig_front || trig_rear) begin
                seen = 1'b1;
                break;
            end
        end
        chk("trig_seen", 32'(seen), 1);
        if (!seen) begin
            abort_run = 1'b1;
            return;
        end
        chk("ping_side", 32'(trig_rear), 32'(v.side));
        if (gap_known) chk("ping_gap", cnt, PING_GAP + 1);

        if (v.kind == K_RESET) begin
            #2;
            RST = 1'b1;
            model_reset();
            #1;
            chk("rst_trig_front", 32'(trig_front), 0);
            chk("rst_trig_rear", 32'(trig_rear), 0);
            chk("rst_front", 32'(front), 0);
            chk("rst_rear", 32'(rear), 0);
            chk("rst_distance", 32'(distance), 0);
            chk("rst_meas_side", 32'(meas_side), 0);
            repeat (2) @(posedge CLK);
            #1 RST = 1'b0;
            gap_known = 1'b0;
            return;
        end

        if (v.kind == K_STUCK_WAIT) set_echo(v.side, 1'b1);
        w = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!(trig_front || trig_rear)) break;
            w++;
        end
        chk("trig_width", w, TRIG_CYCLES);

        case (v.kind)
            K_NONE: begin
                repeat (ECHO_TIMEOUT) @(posedge CLK);
                #1 model_report(v, 1'b1);
            end
            K_STUCK_MEAS: begin
                @(posedge CLK); #1 set_echo(v.side, 1'b1);
                repeat (ECHO_TIMEOUT + 2) @(posedge CLK);
                #1 model_report(v, 1'b1);
                set_echo(v.side, 1'b0);
            end
            K_ABORT: begin
                @(posedge CLK); #1 set_echo(v.side, 1'b1);
                repeat (20) @(posedge CLK);
                #1 enable = 1'b0;
                repeat (3) @(posedge CLK);
                #1 set_echo(v.side, 1'b0);
                chk("abort_trig_low", 32'(trig_front | trig_rear), 0);
                repeat (3) @(posedge CLK);
                #1 enable = 1'b1;
                gap_known = 1'b0;
            end
            default: begin
                if (v.kind == K_STUCK_WAIT) begin
                    repeat (100) @(posedge CLK);
                    #1 set_echo(v.side, 1'b0);
                    repeat (5) @(posedge CLK);
                end else begin
                    @(posedge CLK);
                end
                #1 set_echo(v.side, 1'b1);
                repeat (v.n) @(posedge CLK);
                #1 set_echo(v.side, 1'b0);
                repeat (3) @(posedge CLK);
                #1 model_report(v, 1'b0);
            end
        endcase
    endtask

    task automatic add(input int kind, input int n, input bit side,
                       input logic [4:0] d, input bit flag, input bit strobe);
        vec_t v;
        v.kind = kind; v.n = n; v.side = side;
        v.lit_dist = d; v.lit_flag = flag; v.lit_strobe = strobe;
        vecs.push_back(v);
    endtask

    initial begin
`ifdef DIST_FILTER_EN
        add(K_PULSE,      112, 1'b0, 5'b00000, 1'b0, 1'b0);
        add(K_PULSE,       40, 1'b1, 5'b00000, 1'b0, 1'b0);
        add(K_PULSE,      112, 1'b0, 5'b01010, 1'b1, 1'b1);
        add(K_PULSE,       40, 1'b1, 5'b00010, 1'b1, 1'b1);
        add(K_PULSE,       48, 1'b0, 5'b00010, 1'b1, 1'b0);
        add(K_NONE,         0, 1'b1, 5'b00010, 1'b1, 1'b0);
        add(K_RESET,        0, 1'b0, 5'b00000, 1'b0, 1'b0);
        add(K_PULSE,      112, 1'b0, 5'b00000, 1'b0, 1'b0);
`else
        add(K_PULSE,      112, 1'b0, 5'b01010, 1'b1, 1'b1);
        add(K_PULSE,       40, 1'b1, 5'b00010, 1'b1, 1'b1);
        add(K_PULSE,        8, 1'b0, 5'b00000, 1'b1, 1'b1);
        add(K_RESET,        0, 1'b1, 5'b00000, 1'b0, 1'b0);
        add(K_PULSE,      112, 1'b0, 5'b01010, 1'b1, 1'b1);
        add(K_PULSE,       40, 1'b1, 5'b00010, 1'b1, 1'b1);
        add(K_PULSE,      400, 1'b0, 5'b00000, 1'b0, 1'b1);
        add(K_NONE,         0, 1'b1, 5'b00000, 1'b0, 1'b1);
        add(K_PULSE,       80, 1'b0, 5'b00101, 1'b1, 1'b1);
        add(K_STUCK_WAIT,  40, 1'b1, 5'b00010, 1'b1, 1'b1);
        add(K_PULSE,       96, 1'b0, 5'b01010, 1'b1, 1'b1);
        add(K_STUCK_MEAS,   0, 1'b1, 5'b00000, 1'b0, 1'b1);
        add(K_ABORT,       30, 1'b0, 5'b00000, 1'b0, 1'b0);
        add(K_PULSE,       48, 1'b0, 5'b00011, 1'b1, 1'b1);
        add(K_PULSE,      176, 1'b1, 5'b01111, 1'b1, 1'b1);
        add(K_PULSE,      320, 1'b0, 5'b10100, 1'b1, 1'b1);
        add(K_PULSE,      336, 1'b1, 5'b00000, 1'b0, 1'b1);
`endif
        model_reset();
        enable = 1'b1;
        #1 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_trig_front", 32'(trig_front), 0);
        chk("reset_trig_rear", 32'(trig_rear), 0);
        chk("reset_distance_valid", 32'(distance_valid), 0);
        RST = 1'b0;

        foreach (vecs[i]) begin
            if (abort_run) break;
            run_ping(vecs[i]);
            $display("ping %0d kind=%0d side=%0d distance=%b front=%0d rear=%0d meas_side=%0d",
                     i, vecs[i].kind, vecs[i].side, distance, front, rear, meas_side);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
